tri_bus_ctrl: RTL and testbench

- Half-duplex single-wire bus controller that sits directly upstream of the team's tri_buffer.
- Generates the buffer's data (buf_d) and enable (buf_en) to serialise a transmit word onto a shared line.
- Releases the line for a turnaround gap, then optionally receives a response word from the same line via bus_in.
- Provides a valid/ready transmit interface and a pulsed receive interface to the local logic.

---
 rtl/tri_bus_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_tri_bus_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_bus_ctrl.sv
// Half-duplex single-wire bus controller feeding a tri_buffer.
// Serialises a start/data/stop frame onto the line, releases it for a
// turnaround gap, then optionally receives a response frame from bus_in.
module tri_bus_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BIT_CYC    = 4,
    parameter int unsigned TURN_CYC   = 2,
    parameter int unsigned RX_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_expect,
    output logic             tx_ready,
    output logic             buf_d,
    output logic             buf_en,
    input  logic             bus_in,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_err,
    output logic             rx_timeout,
    output logic             busy
);

    localparam int unsigned HalfCyc = BIT_CYC + BIT_CYC / 2;
    localparam int unsigned MaxA    = (HalfCyc > TURN_CYC) ? HalfCyc : TURN_CYC;
    localparam int unsigned MaxCyc  = (MaxA > RX_TIMEOUT) ? MaxA : RX_TIMEOUT;
    localparam int unsigned CW      = $clog2(MaxCyc + 1);
    localparam int unsigned BW      = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] BitLast  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HalfLast = CW'(HalfCyc - 1);
    localparam logic [CW-1:0] TurnLast = CW'(TURN_CYC - 1);
    localparam logic [CW-1:0] ToLast   = CW'(RX_TIMEOUT - 1);
    localparam logic [BW-1:0] WordLast = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle, StTxStart, StTxData, StTxStop, StTurn, StRxWait, StRxData, StRxStop
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WIDTH-1:0]  tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0]  rx_sh_q, rx_sh_d;
    logic              expect_q, expect_d;
    logic              rx_fire, rx_err_set, rx_to_set;

    logic              tx_ready_q, tx_ready_d;
    logic              buf_d_q, buf_d_d;
    logic              buf_en_q, buf_en_d;
    logic              rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0]  rx_data_q, rx_data_d;
    logic              rx_err_q, rx_err_d;
    logic              rx_to_q, rx_to_d;
    logic              busy_q, busy_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            expect_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            tx_sh_q  <= tx_sh_d;
            rx_sh_q  <= rx_sh_d;
            expect_q <= expect_d;
        end
    end

    // Next-state, bit timing and shift registers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        expect_d   = expect_q;
        rx_fire    = 1'b0;
        rx_err_set = 1'b0;
        rx_to_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_valid && tx_ready_q) begin
                    tx_sh_d  = tx_data;
                    expect_d = tx_expect;
                    cnt_d    = BitLast;
                    state_d  = StTxStart;
                end
            end
            StTxStart: begin
                if (cnt_q == '0) begin
                    cnt_d   = BitLast;
                    bit_d   = '0;
                    state_d = StTxData;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StTxData: begin
                if (cnt_q == '0) begin
                    cnt_d   = BitLast;
                    tx_sh_d = tx_sh_q >> 1;
                    if (bit_q == WordLast) begin
                        state_d = StTxStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StTxStop: begin
                if (cnt_q == '0) begin
                    cnt_d   = TurnLast;
                    state_d = StTurn;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StTurn: begin
                if (cnt_q == '0) begin
                    cnt_d   = ToLast;
                    state_d = expect_q ? StRxWait : StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRxWait: begin
                // A start edge wins over a timeout landing in the same cycle.
                if (!bus_in) begin
                    cnt_d   = HalfLast;
                    bit_d   = '0;
                    state_d = StRxData;
                end else if (cnt_q == '0) begin
                    rx_fire   = 1'b1;
                    rx_to_set = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRxData: begin
                if (cnt_q == '0) begin
                    cnt_d   = BitLast;
                    rx_sh_d = {bus_in, rx_sh_q[WIDTH-1:1]};
                    if (bit_q == WordLast) begin
                        state_d = StRxStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRxStop: begin
                if (cnt_q == '0) begin
                    rx_fire    = 1'b1;
                    rx_err_set = ~bus_in;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        buf_en_d   = (state_d == StTxStart) || (state_d == StTxData) || (state_d == StTxStop);
        buf_d_d    = 1'b1;
        if (state_d == StTxStart) begin
            buf_d_d = 1'b0;
        end else if (state_d == StTxData) begin
            buf_d_d = tx_sh_d[0];
        end
        tx_ready_d = (state_d == StIdle);
        busy_d     = (state_d != StIdle);
        rx_valid_d = rx_fire;
        rx_err_d   = rx_fire & rx_err_set;
        rx_to_d    = rx_fire & rx_to_set;
        rx_data_d  = rx_data_q;
        if (rx_fire) begin
            rx_data_d = rx_to_set ? '0 : rx_sh_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ready_q <= 1'b0;
            buf_d_q    <= 1'b1;
            buf_en_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_err_q   <= 1'b0;
            rx_to_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tx_ready_q <= tx_ready_d;
            buf_d_q    <= buf_d_d;
            buf_en_q   <= buf_en_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_err_q   <= rx_err_d;
            rx_to_q    <= rx_to_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready   = tx_ready_q;
    assign buf_d      = buf_d_q;
    assign buf_en     = buf_en_q;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign rx_err     = rx_err_q;
    assign rx_timeout = rx_to_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_tri_bus_ctrl.sv
// Directed bench for tri_bus_ctrl (WIDTH=8, BIT_CYC=4, TURN_CYC=2, RX_TIMEOUT=64).
// The shared line is modelled as: controller value when buf_en=1, else the
// bench's responder value.
module tb_tri_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_expect;
    logic       tx_ready;
    logic       buf_d;
    logic       buf_en;
    logic       bus_in;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       rx_timeout;
    logic       busy;
    logic       drv;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    assign bus_in = buf_en ? buf_d : drv;

    tri_bus_ctrl #(
        .WIDTH     (8),
        .BIT_CYC   (4),
        .TURN_CYC  (2),
        .RX_TIMEOUT(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_expect (tx_expect),
        .tx_ready  (tx_ready),
        .buf_d     (buf_d),
        .buf_en    (buf_en),
        .bus_in    (bus_in),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_err    (rx_err),
        .rx_timeout(rx_timeout),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Bounded wait for IDLE; leaves the bench in a cycle with tx_ready=1.
    task automatic wait_idle();
        int n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL wait_idle: tx_ready=%b required 1", tx_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (tx_ready !== 1'b0 || buf_en !== 1'b0 || buf_d !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL por_during: ready=%b en=%b d=%b busy=%b required 0 0 1 0",
                     tx_ready, buf_en, buf_d, busy);
        end
        rst = 1'b0;
        tick();
        total++;
        if (tx_ready !== 1'b1 || buf_en !== 1'b0 || buf_d !== 1'b1 || busy !== 1'b0 ||
            rx_valid !== 1'b0 || rx_data !== 8'h00 || rx_err !== 1'b0 || rx_timeout !== 1'b0) begin
            bad++;
            $display("FAIL por_after: ready=%b en=%b d=%b busy=%b rxv=%b rxd=%h err=%b to=%b required 1 0 1 0 0 00 0 0",
                     tx_ready, buf_en, buf_d, busy, rx_valid, rx_data, rx_err, rx_timeout);
        end
        // Abort a frame in the middle of its data bits.
        tx_valid  = 1'b1;
        tx_data   = 8'hA5;
        tx_expect = 1'b0;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (buf_en !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_frame: en=%b busy=%b required 1 1", buf_en, busy);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (buf_en !== 1'b0 || tx_ready !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_during[%0d]: en=%b ready=%b busy=%b required 0 0 0",
                         i, buf_en, tx_ready, busy);
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if (buf_en !== 1'b0 || buf_d !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 ||
            rx_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_after: en=%b d=%b ready=%b busy=%b rxv=%b required 0 1 1 0 0",
                     buf_en, buf_d, tx_ready, busy, rx_valid);
        end
    endtask

    task automatic test_tx_only();
        logic [9:0] fr;
        logic       exp_rdy;
        fr = {1'b1, 8'hA5, 1'b0};
        wait_idle();
        tx_valid  = 1'b1;
        tx_data   = 8'hA5;
        tx_expect = 1'b0;
        for (int c = 1; c <= 43; c++) begin
            tick();
            if (c == 1) tx_valid = 1'b0;
            total++;
            if (c <= 40) begin
                if (buf_en !== 1'b1 || buf_d !== fr[(c-1)/4] || tx_ready !== 1'b0 ||
                    busy !== 1'b1) begin
                    bad++;
                    $display("FAIL tx_frame c=%0d: en=%b d=%b ready=%b busy=%b required 1 %b 0 1",
                             c, buf_en, buf_d, tx_ready, busy, fr[(c-1)/4]);
                end
            end else begin
                exp_rdy = (c == 43);
                if (buf_en !== 1'b0 || buf_d !== 1'b1 || tx_ready !== exp_rdy ||
                    busy !== ~exp_rdy) begin
                    bad++;
                    $display("FAIL tx_turn c=%0d: en=%b d=%b ready=%b busy=%b required 0 1 %b %b",
                             c, buf_en, buf_d, tx_ready, busy, exp_rdy, ~exp_rdy);
                end
            end
        end
    endtask

    // Round trip with 8'h3C out and 8'hC3 back; bad_stop drives the stop bit as 0.
    task automatic test_round_trip(input logic bad_stop);
        logic [9:0] rf;
        logic       exp_v;
        rf = {~bad_stop, 8'hC3, 1'b0};
        wait_idle();
        tx_valid  = 1'b1;
        tx_data   = 8'h3C;
        tx_expect = 1'b1;
        for (int c = 1; c <= 47; c++) begin
            tick();
            if (c == 1) tx_valid = 1'b0;
            total++;
            if (buf_en !== (c <= 40) || rx_valid !== 1'b0) begin
                bad++;
                $display("FAIL rt_out c=%0d: en=%b rxv=%b required %b 0",
                         c, buf_en, rx_valid, (c <= 40));
            end
        end
        // Response start bit begins 5 cycles after the turnaround ends.
        for (int i = 0; i < 40; i++) begin
            tick();
            drv   = rf[i/4];
            exp_v = (i == 39);
            total++;
            if (buf_en !== 1'b0 || rx_valid !== exp_v) begin
                bad++;
                $display("FAIL rt_in i=%0d: en=%b rxv=%b required 0 %b", i, buf_en, rx_valid, exp_v);
            end
            if (exp_v) begin
                total++;
                if (rx_data !== 8'hC3 || rx_err !== bad_stop || rx_timeout !== 1'b0) begin
                    bad++;
                    $display("FAIL rt_result stop_bad=%b: rxd=%h err=%b to=%b required c3 %b 0",
                             bad_stop, rx_data, rx_err, rx_timeout, bad_stop);
                end
            end
        end
        tick();
        drv = 1'b1;
        total++;
        if (rx_valid !== 1'b0 || rx_err !== 1'b0 || rx_timeout !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rt_pulse: rxv=%b err=%b to=%b busy=%b required 0 0 0 0",
                     rx_valid, rx_err, rx_timeout, busy);
        end
    endtask

    task automatic test_timeout();
        logic exp_v;
        wait_idle();
        drv       = 1'b1;
        tx_valid  = 1'b1;
        tx_data   = 8'h5A;
        tx_expect = 1'b1;
        for (int c = 1; c <= 108; c++) begin
            tick();
            if (c == 1) tx_valid = 1'b0;
            exp_v = (c == 107);
            total++;
            if (rx_valid !== exp_v || rx_timeout !== exp_v || rx_err !== 1'b0 ||
                buf_en !== (c <= 40)) begin
                bad++;
                $display("FAIL timeout c=%0d: rxv=%b to=%b err=%b en=%b required %b %b 0 %b",
                         c, rx_valid, rx_timeout, rx_err, buf_en, exp_v, exp_v, (c <= 40));
            end
            if (exp_v) begin
                total++;
                if (rx_data !== 8'h00 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_data: rxd=%h busy=%b required 00 0", rx_data, busy);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] fr1;
        logic [9:0] fr2;
        logic       exp_en;
        logic       exp_d;
        fr1 = {1'b1, 8'h01, 1'b0};
        fr2 = {1'b1, 8'hFF, 1'b0};
        wait_idle();
        tx_valid  = 1'b1;
        tx_data   = 8'h01;
        tx_expect = 1'b0;
        for (int c = 1; c <= 84; c++) begin
            tick();
            if (c == 1) tx_data = 8'hFF;
            if (c == 44) tx_valid = 1'b0;
            exp_en = (c <= 40) || (c >= 44 && c <= 83);
            if (c <= 40) exp_d = fr1[(c-1)/4];
            else if (c >= 44 && c <= 83) exp_d = fr2[(c-44)/4];
            else exp_d = 1'b1;
            total++;
            if (buf_en !== exp_en || buf_d !== exp_d) begin
                bad++;
                $display("FAIL b2b c=%0d: en=%b d=%b required %b %b", c, buf_en, buf_d, exp_en, exp_d);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_expect = 1'b0;
        drv       = 1'b1;
        test_reset();
        test_tx_only();
        test_round_trip(1'b0);
        test_round_trip(1'b1);
        test_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at cycle %0d, required finished", cyc);
        $fatal(1);
    end

endmodule
